sw_debounce: RTL and testbench

Synchronizes and debounces the raw slide-switch bus before it reaches the ones-counting stage, so the LED count never flickers on contact bounce or metastable samples. Each bit passes through a two-flop synchronizer and a per-bit stability counter; the debounced bus only updates after the synchronized level has been stable for a programmable number of cycles. A single-cycle change strobe tells downstream logic when the debounced bus has moved.

---
 rtl/sw_debounce_pkg.sv | 16 +
 rtl/sw_debounce_bit.sv | 53 +++++
 rtl/sw_debounce.sv | 48 ++++
 tb/tb_sw_debounce.sv | 128 ++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: project constants for the switch debouncer.
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles required on hardware (1 ms at 100 MHz)
//   DEBOUNCE_CYCLES_SIM     : short value used by simulation benches
//   cnt_width()             : stability-counter width for a given cycle count
package sw_debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;

    // Counter only ever holds 0 .. cycles-1, so $clog2(cycles) bits suffice;
    // keep at least one bit so the vector is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// debounce_bit: one-bit two-flop synchronizer followed by a stability counter.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   raw     : raw input, asynchronous to clk
//   level   : debounced, registered level
//   update  : combinational strobe, high in the cycle whose closing edge
//             loads a new value into level
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic update
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Accept only once the mismatch has persisted through the terminal count.
    assign update = (sync2 != stable) && (cnt == TERMINAL);
    assign level  = stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                // Any return to the accepted level discards progress.
                cnt <= '0;
            end else if (update) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: synchronizes and debounces the slide-switch bus.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   SW_RAW     : raw switch pins, asynchronous to clk
//   SW         : debounced, registered switch levels
//   SW_CHANGED : one-cycle pulse coinciding with each new SW value
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned BITS            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] SW_RAW,
    output logic [BITS-1:0] SW,
    output logic            SW_CHANGED
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("sw_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [BITS-1:0] upd;

    for (genvar i = 0; i < BITS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (SW_RAW[i]),
            .level (SW[i]),
            .update(upd[i])
        );
    end

    // Registered on the same edge the bit flops load, so the pulse lines up
    // with the new SW value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SW_CHANGED <= 1'b0;
        end else begin
            SW_CHANGED <= |upd;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed self-checking bench for sw_debounce with
// DEBOUNCE_CYCLES = 4 (new level appears 6 edges after first sample).
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_raw = '0;
    logic [15:0] sw;
    logic        sw_changed;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    sw_debounce #(
        .BITS           (16),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SW_RAW    (sw_raw),
        .SW        (sw),
        .SW_CHANGED(sw_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // n edges with SW steady and no strobe
    task automatic hold(input string tag, input int unsigned n, input logic [15:0] exp_sw);
        for (int unsigned i = 0; i < n; i++) begin
            edge1();
            check({tag, "_sw_hold"}, sw, exp_sw);
            check({tag, "_chg_hold"}, {15'd0, sw_changed}, 16'd0);
        end
    endtask

    // Apply a raw level and expect acceptance on exactly the 6th edge.
    task automatic transition(input string tag, input logic [15:0] raw,
                              input logic [15:0] old_sw, input logic [15:0] new_sw);
        sw_raw = raw;
        hold(tag, 5, old_sw);
        edge1();
        check({tag, "_sw_new"}, sw, new_sw);
        check({tag, "_chg_pulse"}, {15'd0, sw_changed}, 16'd1);
        edge1();
        check({tag, "_sw_after"}, sw, new_sw);
        check({tag, "_chg_after"}, {15'd0, sw_changed}, 16'd0);
    endtask

    initial begin
        // Reset held with all switches high
        sw_raw = 16'hFFFF;
        rst_n  = 1'b0;
        #1;
        hold("reset", 10, 16'h0000);
        rst_n = 1'b1;
        transition("rel", 16'hFFFF, 16'h0000, 16'hFFFF);

        // Clean transitions
        transition("clr", 16'h0000, 16'hFFFF, 16'h0000);
        transition("clean", 16'h0001, 16'h0000, 16'h0001);

        // Bounce on bit 3, then settle high
        for (int unsigned i = 0; i < 10; i++) begin
            sw_raw = (i % 2 == 0) ? 16'h0009 : 16'h0001;
            edge1();
            check("bounce_sw", sw, 16'h0001);
            check("bounce_chg", {15'd0, sw_changed}, 16'd0);
        end
        transition("settle", 16'h0009, 16'h0001, 16'h0009);

        // 3-cycle glitch on bit 7
        sw_raw = 16'h0089;
        hold("glitch_hi", 3, 16'h0009);
        sw_raw = 16'h0009;
        hold("glitch_lo", 10, 16'h0009);

        // Simultaneous bits 0/15, bit 8 two cycles later
        transition("clr2", 16'h0000, 16'h0009, 16'h0000);
        sw_raw = 16'h8001;
        hold("sim_a", 2, 16'h0000);
        sw_raw = 16'h8101;
        hold("sim_b", 3, 16'h0000);
        edge1();
        check("sim_sw1", sw, 16'h8001);
        check("sim_chg1", {15'd0, sw_changed}, 16'd1);
        edge1();
        check("sim_gap_sw", sw, 16'h8001);
        check("sim_gap_chg", {15'd0, sw_changed}, 16'd0);
        edge1();
        check("sim_sw2", sw, 16'h8101);
        check("sim_chg2", {15'd0, sw_changed}, 16'd1);
        edge1();
        check("sim_end_chg", {15'd0, sw_changed}, 16'd0);

        // Reset in the middle of a bit-2 count
        sw_raw = 16'h8105;
        hold("mid", 4, 16'h8101);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sw", sw, 16'h0000);
        check("mid_rst_chg", {15'd0, sw_changed}, 16'd0);
        hold("mid_held", 3, 16'h0000);
        rst_n = 1'b1;
        transition("mid_rel", 16'h8105, 16'h0000, 16'h8105);

        // Steady input: no repeated strobes
        hold("steady", 20, 16'h8105);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
